id_hazard_scoreboard: RTL and testbench
=======================================

Name: id_hazard_scoreboard

Overview:
- Issue controller for the decode stage: decides each cycle whether the instruction held in ID may issue to EXE, or must stall.
- Tracks registers with pending writes in a 32-entry scoreboard and caps the number of in-flight instructions.
- Inserts a fixed bubble window after every issued branch.
- Sits between the IF/ID register and the ID/EXE register; drives the freeze of both.

Parameters:
- MAX_INFLIGHT, 4, maximum issued-but-not-retired instructions (1..15).
- BR_SHADOW, 2, stall cycles forced after a branch issues (0..7; 0 disables the window).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- id_valid  input  1  ID holds a valid instruction.
- src1  input  5  first source register (Instruction[25:21]).
- src2  input  5  second source register (Instruction[20:16]).
- src2_used  input  1  src2 is read (R-type, store, branch compare).
- id_dest  input  5  destination register of the ID instruction.
- id_wb_en  input  1  ID instruction writes the register file.
- id_br_type  input  2  branch type from the control unit; 0 means not a branch.
- WB_Write_Enable  input  1  writeback writes the register file this cycle.
- WB_Dest  input  5  writeback destination register.
- retire  input  1  one instruction leaves the pipeline this cycle.
- flush  input  1  taken branch resolved in EXE; cancels the remaining branch window.
- stall  output  1  freeze the PC and IF/ID; insert a bubble into ID/EXE.
- issue  output  1  id_valid & ~stall.
- inflight  output  4  current in-flight count.
- underflow_err  output  1  sticky; set when retire arrives while inflight == 0.

Behaviour:
- Reset (rst low, asynchronous):
  - scoreboard = 0, inflight = 0, br_cnt = 0, underflow_err = 0.
  - Outputs stall = 0 and issue = 0, regardless of id_valid.
- Register 0 is never marked pending; src or dest equal to 0 never causes a hazard.
- raw_hz: (sb[src1] & src1 != 0) | (src2_used & sb[src2] & src2 != 0).
- waw_hz: id_wb_en & id_dest != 0 & sb[id_dest].
- full_hz: inflight == MAX_INFLIGHT & ~retire. A retire in the same cycle frees the slot combinationally.
- br_hz: br_cnt != 0 & ~flush.
- stall = id_valid & (raw_hz | waw_hz | full_hz | br_hz). The logic is combinational from state and inputs, with zero-cycle latency.
- Scoreboard update at each edge:
  - Clear sb[WB_Dest] when WB_Write_Enable & WB_Dest != 0.
  - Set sb[id_dest] when issue & id_wb_en & id_dest != 0.
  - If the same register is set and cleared in one cycle, set wins, because the issuing instruction is younger.
- In-flight counter:
  - +1 on issue, -1 on retire; both together leave it unchanged.
  - retire at 0 leaves it at 0 and sets underflow_err. Only reset clears underflow_err.
  - Overflow is impossible, because issue is blocked at MAX_INFLIGHT.
- Branch window:
  - On issue with id_br_type != 0, br_cnt loads BR_SHADOW.
  - Otherwise br_cnt decrements while nonzero.
  - flush forces br_cnt to 0 at the edge and masks br_hz in the same cycle.
  - flush does not alter the scoreboard or inflight, because already-issued instructions still write back and retire.
- id_valid = 0: stall = 0, issue = 0, and no set or issue-side counter change. Writeback clears and retire still apply.
- The block has no internal FSM other than br_cnt. It is states IDLE (br_cnt == 0) and SHADOW (br_cnt > 0): IDLE goes to SHADOW on a branch issue; SHADOW goes to IDLE on count reaching 0 or on flush.

Optional Feature:
- Macro WB_BYPASS_EN.
- When defined: a source whose scoreboard bit is being cleared by writeback in the current cycle (WB_Write_Enable & WB_Dest == src) does not raise raw_hz. This requires the register file to forward write data to reads in the same cycle.
- When undefined: raw_hz uses the registered scoreboard only, and the instruction issues one cycle after writeback.

Test Plan:
- Reset, then issue r3 = op(r1, r2) with id_wb_en, then next instruction reads r3 -> sb[3] = 1. The reader sees stall = 1 until WB_Dest = 3 writes back. The reader issues in the same cycle with WB_BYPASS_EN defined, or one cycle later without it.
- Issue writing r0, then a reader of r0 -> sb stays all zeros, and the reader never stalls.
- MAX_INFLIGHT = 4: issue 4 instructions with no retire -> inflight = 4, and a 5th valid instruction sees stall = 1. Assert retire in that cycle -> stall = 0, issue = 1, and inflight stays 4.
- BR_SHADOW = 2: issue a beq -> the next 2 cycles have stall = 1 and br_cnt goes 2, 1, 0. Repeat with flush in the first shadow cycle -> stall = 0 that cycle, and br_cnt = 0 after the edge.
- Same-cycle set and clear: ID issues a write to r5 while WB clears r5 -> sb[5] = 1 after the edge.
- Assert retire with inflight = 0 -> underflow_err = 1 and inflight = 0. Drive rst low mid-stream with sb nonzero -> all state is 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/id_hazard_scoreboard.sv
// Purpose : decode-stage issue controller; RAW/WAW scoreboard, in-flight cap, branch bubble window.
// Latency : stall/issue are combinational from state and inputs (0 cycles); state updates on clk rising edge.
// Backpress: stall freezes PC and IF/ID and bubbles ID/EXE; held until every hazard clears.
//
// Optional feature: define WB_BYPASS_EN to let a source being written back this cycle
// issue in the same cycle (register file forwards write data to reads).
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   id_valid            ID holds a valid instruction
//   src1, src2          source registers; src2_used qualifies src2
//   id_dest, id_wb_en   destination of the ID instruction and its write enable
//   id_br_type          nonzero for a branch
//   WB_Write_Enable,
//   WB_Dest             writeback port; clears the pending bit of WB_Dest
//   retire              one instruction leaves the pipeline
//   flush               taken branch resolved in EXE; cancels the branch window
//   stall, issue        issue decision for the ID instruction
//   inflight            issued-but-not-retired count
//   underflow_err       sticky: retire seen while inflight == 0
module id_hazard_scoreboard #(
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned BR_SHADOW    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] src1,
  input  logic [4:0] src2,
  input  logic       src2_used,
  input  logic [4:0] id_dest,
  input  logic       id_wb_en,
  input  logic [1:0] id_br_type,
  input  logic       WB_Write_Enable,
  input  logic [4:0] WB_Dest,
  input  logic       retire,
  input  logic       flush,
  output logic       stall,
  output logic       issue,
  output logic [3:0] inflight,
  output logic       underflow_err
);

  localparam logic [3:0] MAX_CNT    = 4'(MAX_INFLIGHT);
  localparam logic [2:0] SHADOW_CNT = 3'(BR_SHADOW);

  typedef enum logic {S_IDLE, S_SHADOW} br_state_t;

  logic [31:0] sb, sb_nxt;
  logic [3:0]  inflight_nxt;
  logic        underflow_nxt;
  logic [2:0]  br_cnt, br_cnt_nxt;
  br_state_t   br_state, br_state_nxt;

  logic src1_pend, src2_pend;
  logic raw_hz, waw_hz, full_hz, br_hz;

`ifdef WB_BYPASS_EN
  // A source cleared by writeback this cycle is read through the register file bypass.
  assign src1_pend = sb[src1] & ~(WB_Write_Enable & (WB_Dest == src1));
  assign src2_pend = sb[src2] & ~(WB_Write_Enable & (WB_Dest == src2));
`else
  assign src1_pend = sb[src1];
  assign src2_pend = sb[src2];
`endif

  assign raw_hz  = (src1_pend & (src1 != 5'd0)) |
                   (src2_used & src2_pend & (src2 != 5'd0));
  assign waw_hz  = id_wb_en & (id_dest != 5'd0) & sb[id_dest];
  // A retire this cycle frees a slot for the ID instruction immediately.
  assign full_hz = (inflight == MAX_CNT) & ~retire;
  assign br_hz   = (br_state == S_SHADOW) & ~flush;

  // Gated by rst so both outputs are quiet while reset is held.
  assign stall = rst & id_valid & (raw_hz | waw_hz | full_hz | br_hz);
  assign issue = rst & id_valid & ~stall;

  always_comb begin
    sb_nxt = sb;
    if (WB_Write_Enable && (WB_Dest != 5'd0)) sb_nxt[WB_Dest] = 1'b0;
    // Set after clear: the issuing instruction is younger than the one writing back.
    if (issue && id_wb_en && (id_dest != 5'd0)) sb_nxt[id_dest] = 1'b1;
    sb_nxt[0] = 1'b0;
  end

  always_comb begin
    inflight_nxt  = inflight;
    underflow_nxt = underflow_err;
    if (retire && (inflight == 4'd0)) underflow_nxt = 1'b1;
    case ({issue, retire})
      2'b10:   inflight_nxt = inflight + 4'd1;
      2'b01:   if (inflight != 4'd0) inflight_nxt = inflight - 4'd1;
      default: inflight_nxt = inflight;
    endcase
  end

  // Branch window: IDLE <-> SHADOW tracks br_cnt being nonzero.
  always_comb begin
    br_cnt_nxt   = br_cnt;
    br_state_nxt = br_state;
    if (flush)
      br_cnt_nxt = 3'd0;
    else if (issue && (id_br_type != 2'd0))
      br_cnt_nxt = SHADOW_CNT;
    else if (br_cnt != 3'd0)
      br_cnt_nxt = br_cnt - 3'd1;
    br_state_nxt = (br_cnt_nxt != 3'd0) ? S_SHADOW : S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb            <= 32'd0;
      inflight      <= 4'd0;
      underflow_err <= 1'b0;
      br_cnt        <= 3'd0;
      br_state      <= S_IDLE;
    end else begin
      sb            <= sb_nxt;
      inflight      <= inflight_nxt;
      underflow_err <= underflow_nxt;
      br_cnt        <= br_cnt_nxt;
      br_state      <= br_state_nxt;
    end
  end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Purpose : directed scoreboard bench for id_hazard_scoreboard (MAX_INFLIGHT=4, BR_SHADOW=2).
// Latency : expectations are pushed at posedge+1 and popped by the monitor on the following negedge.
// Backpress: none; one expectation per driven cycle.
module tb_id_hazard_scoreboard;

  logic       clk, rst;
  logic       id_valid, src2_used, id_wb_en, WB_Write_Enable, retire, flush;
  logic [4:0] src1, src2, id_dest, WB_Dest;
  logic [1:0] id_br_type;
  logic       stall, issue, underflow_err;
  logic [3:0] inflight;

  id_hazard_scoreboard #(.MAX_INFLIGHT(4), .BR_SHADOW(2)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
    .src2_used(src2_used), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_br_type(id_br_type), .WB_Write_Enable(WB_Write_Enable), .WB_Dest(WB_Dest),
    .retire(retire), .flush(flush), .stall(stall), .issue(issue),
    .inflight(inflight), .underflow_err(underflow_err)
  );

  typedef struct packed {
    logic        stall;
    logic        issue;
    logic [3:0]  infl;
    logic        uf;
    logic [31:0] sb;
    logic [2:0]  br;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: every negedge with a pending expectation compares the DUT outputs.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e  = q.pop_front();
        nm = nq.pop_front();
        cmp({nm, ".stall"},    {31'd0, stall},          {31'd0, e.stall});
        cmp({nm, ".issue"},    {31'd0, issue},          {31'd0, e.issue});
        cmp({nm, ".inflight"}, {28'd0, inflight},       {28'd0, e.infl});
        cmp({nm, ".underflow"},{31'd0, underflow_err},  {31'd0, e.uf});
        cmp({nm, ".sb"},       dut.sb,                  e.sb);
        cmp({nm, ".br_cnt"},   {29'd0, dut.br_cnt},     {29'd0, e.br});
      end
    end
  end

  task automatic clr();
    id_valid = 0; src1 = 0; src2 = 0; src2_used = 0; id_dest = 0; id_wb_en = 0;
    id_br_type = 0; WB_Write_Enable = 0; WB_Dest = 0; retire = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic expect_out(input logic s, input logic i, input logic [3:0] n,
                            input logic u, input logic [31:0] b, input logic [2:0] c,
                            input string nm);
    exp_t e;
    e.stall = s; e.issue = i; e.infl = n; e.uf = u; e.sb = b; e.br = c;
    q.push_back(e);
    nq.push_back(nm);
  endtask

  initial begin
    rst = 1'b0;
    clr();
    // Reset: outputs quiet even with a valid instruction present.
    tick(); id_valid = 1; src1 = 5'd3;
    expect_out(0, 0, 4'd0, 0, 32'h0, 3'd0, "reset");

    // RAW: r3 = op(r1, r2), then a reader of r3.
    tick(); rst = 1;
    id_valid = 1; src1 = 5'd1; src2 = 5'd2; src2_used = 1; id_dest = 5'd3; id_wb_en = 1;
    expect_out(0, 1, 4'd0, 0, 32'h0, 3'd0, "raw_writer");
    tick(); id_valid = 1; src1 = 5'd3; id_dest = 5'd4; id_wb_en = 1;
    expect_out(1, 0, 4'd1, 0, 32'h8, 3'd0, "raw_stall");
    tick(); id_valid = 1; src1 = 5'd3; id_dest = 5'd4; id_wb_en = 1;
    WB_Write_Enable = 1; WB_Dest = 5'd3;
`ifdef WB_BYPASS_EN
    expect_out(0, 1, 4'd1, 0, 32'h8, 3'd0, "raw_wb_cycle");
    tick();
    expect_out(0, 0, 4'd2, 0, 32'h10, 3'd0, "raw_after_wb");
`else
    expect_out(1, 0, 4'd1, 0, 32'h8, 3'd0, "raw_wb_cycle");
    tick(); id_valid = 1; src1 = 5'd3; id_dest = 5'd4; id_wb_en = 1;
    expect_out(0, 1, 4'd1, 0, 32'h0, 3'd0, "raw_after_wb");
`endif
    tick(); retire = 1; WB_Write_Enable = 1; WB_Dest = 5'd4;
    expect_out(0, 0, 4'd2, 0, 32'h10, 3'd0, "raw_drain0");
    tick(); retire = 1;
    expect_out(0, 0, 4'd1, 0, 32'h0, 3'd0, "raw_drain1");

    // Register 0 never becomes pending.
    tick(); id_valid = 1; id_dest = 5'd0; id_wb_en = 1;
    expect_out(0, 1, 4'd0, 0, 32'h0, 3'd0, "r0_write");
    tick(); id_valid = 1; src2_used = 1; id_dest = 5'd6;
    expect_out(0, 1, 4'd1, 0, 32'h0, 3'd0, "r0_read");
    tick(); retire = 1;
    expect_out(0, 0, 4'd2, 0, 32'h0, 3'd0, "r0_drain0");
    tick(); retire = 1;
    expect_out(0, 0, 4'd1, 0, 32'h0, 3'd0, "r0_drain1");

    // In-flight cap.
    for (int k = 0; k < 4; k++) begin
      tick(); id_valid = 1;
      expect_out(0, 1, 4'(k), 0, 32'h0, 3'd0, "full_fill");
    end
    tick(); id_valid = 1;
    expect_out(1, 0, 4'd4, 0, 32'h0, 3'd0, "full_stall");
    tick(); id_valid = 1; retire = 1;
    expect_out(0, 1, 4'd4, 0, 32'h0, 3'd0, "full_retire_issue");
    for (int k = 4; k > 0; k--) begin
      tick(); retire = 1;
      expect_out(0, 0, 4'(k), 0, 32'h0, 3'd0, "full_drain");
    end

    // Branch window, then branch window cut short by flush.
    tick(); id_valid = 1; id_br_type = 2'd1;
    expect_out(0, 1, 4'd0, 0, 32'h0, 3'd0, "br_issue");
    tick(); id_valid = 1;
    expect_out(1, 0, 4'd1, 0, 32'h0, 3'd2, "br_shadow0");
    tick(); id_valid = 1;
    expect_out(1, 0, 4'd1, 0, 32'h0, 3'd1, "br_shadow1");
    tick(); id_valid = 1;
    expect_out(0, 1, 4'd1, 0, 32'h0, 3'd0, "br_done");
    tick(); id_valid = 1; id_br_type = 2'd2;
    expect_out(0, 1, 4'd2, 0, 32'h0, 3'd0, "br2_issue");
    tick(); id_valid = 1; flush = 1;
    expect_out(0, 1, 4'd3, 0, 32'h0, 3'd2, "br2_flush");
    tick();
    expect_out(0, 0, 4'd4, 0, 32'h0, 3'd0, "br2_after_flush");
    for (int k = 4; k > 0; k--) begin
      tick(); retire = 1;
      expect_out(0, 0, 4'(k), 0, 32'h0, 3'd0, "br_drain");
    end

    // Same-cycle set and clear of r5: set wins.
    tick(); id_valid = 1; id_dest = 5'd5; id_wb_en = 1; WB_Write_Enable = 1; WB_Dest = 5'd5;
    expect_out(0, 1, 4'd0, 0, 32'h0, 3'd0, "setclr");
    tick(); retire = 1;
    expect_out(0, 0, 4'd1, 0, 32'h20, 3'd0, "setclr_after");

    // Underflow is sticky; inflight stays at 0.
    tick(); retire = 1;
    expect_out(0, 0, 4'd0, 0, 32'h20, 3'd0, "uf_retire_at0");
    tick(); id_valid = 1; src1 = 5'd5;
    expect_out(1, 0, 4'd0, 1, 32'h20, 3'd0, "uf_sticky");

    // Asynchronous reset mid-cycle clears everything without a clock edge.
    tick(); id_valid = 1; src1 = 5'd5; rst = 0;
    expect_out(0, 0, 4'd0, 0, 32'h0, 3'd0, "async_rst");
    tick(); rst = 1; id_valid = 1; src1 = 5'd5;
    expect_out(0, 1, 4'd0, 0, 32'h0, 3'd0, "post_rst_issue");

    tick();
    tick();
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain actual=%0d required=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
